add_header_arb: RTL
===================

Name: add_header_arb

Overview:
- Multi-channel successor to the single-stream header inserter.
- Accepts NCH packet-data streams, each with a companion packet-length stream.
- Arbitrates round-robin between channels and emits each packet on one output stream, preceded by a 1-cycle header carrying length and source channel.
- Output is fully registered (one-slot pipeline register) for timing closure at the network-stack boundary.

Parameters:
- DW, 128, data width in bits; must be a multiple of 8 and at least 64.
- NCH, 4, number of input channels; 1 to 16.
- CW, $clog2(NCH) with minimum 1, grant/channel index width (localparam).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- axis_data_tdata  in  NCH*DW  channel i occupies bits [i*DW +: DW].
- axis_data_tkeep  in  NCH*DW/8  channel i occupies bits [i*DW/8 +: DW/8].
- axis_data_tlast  in  NCH  per-channel end of packet.
- axis_data_tvalid  in  NCH  per-channel valid.
- axis_data_tready  out  NCH  per-channel ready.
- axis_plen_tdata  in  NCH*16  per-channel packet length in bytes.
- axis_plen_tvalid  in  NCH  per-channel length valid.
- axis_plen_tready  out  NCH  per-channel length ready.
- axis_out_tdata  out  DW  output data (registered).
- axis_out_tkeep  out  DW/8  output keep (registered).
- axis_out_tlast  out  1  output last (registered).
- axis_out_tvalid  out  1  output valid (registered).
- axis_out_tready  in  1  output ready.
- cur_chan  out  CW  channel currently granted (registered).

Behaviour:
- Reset: asynchronous, active low.
  - All axis_out_* = 0, cur_chan = 0, all tready = 0.
  - State = ARB; round-robin pointer last = NCH-1, so channel 0 has first priority.
  - Reset mid-packet discards the in-flight packet with no output completion; the bench must also reset upstream sources.
- Output slot accepts a new beat when slot_free = ~axis_out_tvalid | axis_out_tready. This gives full throughput: 1 beat/cycle under continuous ready.
- Latency: 1 clk from input handshake to axis_out_tvalid.
- ARB state:
  - All tready = 0.
  - Pick the first i with axis_plen_tvalid[i], searching last+1, last+2, ... modulo NCH.
  - If one is found: register grant = i, cur_chan = i, last = i, go to HDR.
  - If none is found: stay in ARB.
  - ARB costs 1 idle cycle per packet; this is accepted.
- HDR state:
  - axis_plen_tready[grant] = slot_free; all other tready = 0.
  - On plen handshake, load the output register with the header:
    - tdata[15:0] = plen.
    - tdata[23:16] = grant, zero-extended.
    - All remaining bits 0.
    - tkeep all ones, tlast 0, tvalid 1.
  - Then go to DATA.
- DATA state:
  - axis_data_tready[grant] = slot_free; all other tready = 0.
  - Each data handshake copies tdata, tkeep and tlast into the output register with tvalid 1.
  - A handshake with tlast = 1 moves the state to ARB.
- When slot_free and no input handshake occurs, axis_out_tvalid clears to 0.
- While axis_out_tvalid = 1 and axis_out_tready = 0, output registers hold stable (AXIS rule).
- No length checking: plen = 0 or a plen that mismatches the actual byte count passes through unchanged.
- A channel's data presented before its plen is ignored; it is only accepted in DATA with that channel granted.
- Non-granted channels with tvalid asserted wait; grant never changes mid-packet.
- NCH = 1 degenerates to the single-stream behaviour with a registered output and a channel field of 0.

Optional Feature:
- Macro: ADD_HEADER_ARB_SEQNUM_EN.
- Defined:
  - A 16-bit per-channel sequence counter array (reset 0).
  - Header tdata[47:32] = seq[grant].
  - seq[grant] increments on each header handshake and wraps 0xFFFF -> 0x0000.
- Undefined: header bits [47:32] = 0 and no counters are synthesised.

Test Plan:
- NCH=4, ch0 plen=40, 3 beats (tkeep last = 0x00FF) -> out header tdata=0x0028 with [23:16]=0, then 3 beats identical; tlast only on beat 3; cur_chan=0.
- ch1 and ch3 plen valid on the same cycle after reset -> ch1 packet fully output before ch3 header; header channel fields 1 then 3.
- All 4 channels continuously valid with 2-beat packets -> header channel sequence 0,1,2,3,0; no interleaving of beats across packets.
- axis_out_tready toggled 1,0,0,1 during DATA -> out tdata/tvalid stable while stalled; no beat lost or duplicated; data tready follows slot_free.
- resetn pulsed low mid-packet on ch2 -> all outputs 0 immediately (asynchronous); after release, first grant goes to ch0 if valid.
- With ADD_HEADER_ARB_SEQNUM_EN, 3 packets on ch0 -> header [47:32] = 0,1,2; force seq=0xFFFF -> next header 0xFFFF, following one 0x0000.

Source files
------------

// File: rtl/add_header_arb.sv
// add_header_arb: round-robin arbiter over NCH AXIS channels, prefixing each packet with a 1-beat length/channel header.
// Define ADD_HEADER_ARB_SEQNUM_EN to place a per-channel 16-bit sequence number in header bits [47:32].
module add_header_arb #(
    parameter int DW  = 128,
    parameter int NCH = 4,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH*DW-1:0]     axis_data_tdata,
    input  logic [NCH*DW/8-1:0]   axis_data_tkeep,
    input  logic [NCH-1:0]        axis_data_tlast,
    input  logic [NCH-1:0]        axis_data_tvalid,
    output logic [NCH-1:0]        axis_data_tready,
    input  logic [NCH*16-1:0]     axis_plen_tdata,
    input  logic [NCH-1:0]        axis_plen_tvalid,
    output logic [NCH-1:0]        axis_plen_tready,
    output logic [DW-1:0]         axis_out_tdata,
    output logic [DW/8-1:0]       axis_out_tkeep,
    output logic                  axis_out_tlast,
    output logic                  axis_out_tvalid,
    input  logic                  axis_out_tready,
    output logic [CW-1:0]         cur_chan
);
    typedef enum logic [1:0] {ARB, HDR, DATA} state_e;
    state_e          state_q, state_d;
    logic [CW-1:0]   grant_q, grant_d, last_q, last_d, pick;
    logic [DW-1:0]   tdata_q, tdata_d, hdr;
    logic [DW/8-1:0] tkeep_q, tkeep_d;
    logic            tlast_q, tlast_d, tvalid_q, tvalid_d;
    logic            slot_free, found, hdr_hs, dat_hs;
    logic [15:0]     plen;
`ifdef ADD_HEADER_ARB_SEQNUM_EN
    logic [15:0]     seq_q [NCH];
`endif

    assign slot_free = ~tvalid_q | axis_out_tready;
    assign plen      = axis_plen_tdata[int'(grant_q)*16 +: 16];
    assign hdr_hs    = (state_q == HDR) && axis_plen_tvalid[grant_q] && slot_free;
    assign dat_hs    = (state_q == DATA) && axis_data_tvalid[grant_q] && slot_free;

    // search starts just after the last winner so every channel gets a turn
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int k = 1; k <= NCH; k++) begin
            if (!found && axis_plen_tvalid[(int'(last_q) + k) % NCH]) begin
                found = 1'b1;
                pick  = CW'((int'(last_q) + k) % NCH);
            end
        end
    end

    always_comb begin
        hdr        = '0;
        hdr[15:0]  = plen;
        hdr[23:16] = 8'(grant_q);
`ifdef ADD_HEADER_ARB_SEQNUM_EN
        hdr[47:32] = seq_q[grant_q];
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ARB;
            grant_q  <= '0;
            last_q   <= CW'(NCH - 1);
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ARB: if (found) begin
                state_d = HDR;
                grant_d = pick;
                last_d  = pick;
            end
            HDR:  state_d = hdr_hs ? DATA : HDR;
            DATA: state_d = (dat_hs && axis_data_tlast[grant_q]) ? ARB : DATA;
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        tvalid_d = slot_free ? (hdr_hs | dat_hs) : tvalid_q;
        tdata_d  = hdr_hs ? hdr : dat_hs ? axis_data_tdata[int'(grant_q)*DW +: DW] : tdata_q;
        tkeep_d  = hdr_hs ? '1 : dat_hs ? axis_data_tkeep[int'(grant_q)*(DW/8) +: DW/8] : tkeep_q;
        tlast_d  = hdr_hs ? 1'b0 : dat_hs ? axis_data_tlast[grant_q] : tlast_q;
        axis_plen_tready = '0;
        axis_data_tready = '0;
        axis_plen_tready[grant_q] = (state_q == HDR) && slot_free;
        axis_data_tready[grant_q] = (state_q == DATA) && slot_free;
    end

`ifdef ADD_HEADER_ARB_SEQNUM_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) seq_q[i] <= '0;
        end else if (hdr_hs) begin
            seq_q[grant_q] <= seq_q[grant_q] + 16'd1;
        end
    end
`endif

    assign axis_out_tdata  = tdata_q;
    assign axis_out_tkeep  = tkeep_q;
    assign axis_out_tlast  = tlast_q;
    assign axis_out_tvalid = tvalid_q;
    assign cur_chan        = grant_q;
endmodule
